// File: rtl/nmi_bus_arb_pkg.sv
// Shared types for the two-master NMI arbiter.
// Defines FSM states, master indices and the abort read-data default.
package nmi_bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ARB,
        ARB_CORE,
        ARB_DMA
    } arb_state_e;

    localparam int unsigned MST_CORE = 0;
    localparam int unsigned MST_DMA  = 1;

    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/nmi_bus_arb.sv
// Two-master NMI arbiter: core has priority, DMA has a starvation guard,
// and a watchdog aborts hung slave accesses.
// Ports: clk_i/rst_n_i; core_* and dma_* master NMI ports (valid, addr,
// wdata, wstrb in; ready, rdata out); s_* fabric NMI port; gnt_o one-hot
// owner {dma,core}; timeout_o sticky abort flag.
module nmi_bus_arb
    import nmi_bus_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM  = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        core_valid_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_wstrb_i,
    output logic        core_ready_o,
    output logic [31:0] core_rdata_o,
    input  logic        dma_valid_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    input  logic [3:0]  dma_wstrb_i,
    output logic        dma_ready_o,
    output logic [31:0] dma_rdata_o,
    output logic        s_valid_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_wdata_o,
    output logic [3:0]  s_wstrb_o,
    input  logic        s_ready_i,
    input  logic [31:0] s_rdata_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    arb_state_e      state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;

    logic own_core;
    logic own_dma;
    logic own_valid;
    logic abort;
    logic dma_win;

    assign own_core  = (state_q == ARB_CORE);
    assign own_dma   = (state_q == ARB_DMA);
    assign own_valid = (own_core & core_valid_i) | (own_dma & dma_valid_i);

    // A watchdog abort only happens while the owner is still requesting;
    // a same-cycle fabric ready turns it into a normal completion.
    assign abort = own_valid & ~s_ready_i & (wd_q == WD_LAST);

    assign dma_win = dma_valid_i &
                     (~core_valid_i | (starve_q == STARVE_MAX));

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (core_valid_i | dma_valid_i) begin
                    state_d = ARB_ARB;
                end
            end
            ARB_ARB: begin
                if (dma_win) begin
                    state_d  = ARB_DMA;
                    starve_d = '0;
                    wd_d     = '0;
                end else if (core_valid_i) begin
                    state_d = ARB_CORE;
                    wd_d    = '0;
                    if (dma_valid_i && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_CORE, ARB_DMA: begin
                // Dropped valid, completion and abort all leave via IDLE,
                // which provides the bubble that hides a stale valid.
                if (!own_valid || s_ready_i) begin
                    state_d = ARB_IDLE;
                end else if (abort) begin
                    state_d   = ARB_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ARB_IDLE;
            starve_q  <= '0;
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        s_valid_o    = own_valid & ~abort;
        s_addr_o     = own_dma ? dma_addr_i  : core_addr_i;
        s_wdata_o    = own_dma ? dma_wdata_i : core_wdata_i;
        s_wstrb_o    = own_dma ? dma_wstrb_i : core_wstrb_i;
        core_ready_o = own_core & (s_ready_i | abort);
        dma_ready_o  = own_dma & (s_ready_i | abort);
        core_rdata_o = '0;
        dma_rdata_o  = '0;
        if (own_core) begin
            core_rdata_o = abort ? ERR_RDATA : s_rdata_i;
        end
        if (own_dma) begin
            dma_rdata_o = abort ? ERR_RDATA : s_rdata_i;
        end
        gnt_o           = '0;
        gnt_o[MST_CORE] = own_core;
        gnt_o[MST_DMA]  = own_dma;
        timeout_o       = timeout_q;
    end

endmodule

// File: tb/tb_nmi_bus_arb.sv
// Directed bench for nmi_bus_arb with a completion scoreboard,
// a behavioural fabric slave and immediate-assertion checks.
module tb_nmi_bus_arb;

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n_i;
    logic        core_valid_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wdata_i;
    logic [3:0]  core_wstrb_i;
    logic        core_ready_o;
    logic [31:0] core_rdata_o;
    logic        dma_valid_i;
    logic [31:0] dma_addr_i;
    logic [31:0] dma_wdata_i;
    logic [3:0]  dma_wstrb_i;
    logic        dma_ready_o;
    logic [31:0] dma_rdata_o;
    logic        s_valid_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic        s_ready_i;
    logic [31:0] s_rdata_i;
    logic [1:0]  gnt_o;
    logic        timeout_o;

    int checks;
    int errors;
    int done_cnt;
    exp_t exp_q[$];

    int          slave_lat;
    logic        slave_fixed;
    logic [31:0] slave_rdata;
    int          scnt;

    nmi_bus_arb #(
        .STARVE_LIM (4),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .core_valid_i(core_valid_i),
        .core_addr_i (core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_wstrb_i(core_wstrb_i),
        .core_ready_o(core_ready_o),
        .core_rdata_o(core_rdata_o),
        .dma_valid_i (dma_valid_i),
        .dma_addr_i  (dma_addr_i),
        .dma_wdata_i (dma_wdata_i),
        .dma_wstrb_i (dma_wstrb_i),
        .dma_ready_o (dma_ready_o),
        .dma_rdata_o (dma_rdata_o),
        .s_valid_o   (s_valid_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_wstrb_o   (s_wstrb_o),
        .s_ready_i   (s_ready_i),
        .s_rdata_i   (s_rdata_i),
        .gnt_o       (gnt_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done(input int n, input int lim);
        for (int i = 0; i < lim && done_cnt < n; i++) @(posedge clk);
        #1;
        chk("done_cnt", done_cnt, n);
    endtask

    task automatic wait_gnt(input logic [1:0] want);
        for (int i = 0; i < 10 && gnt_o !== want; i++) nclk();
        chk("wait_gnt", {30'd0, gnt_o}, {30'd0, want});
    endtask

    // Fabric slave: ready in owner cycle slave_lat (0 = never).
    initial begin
        s_ready_i = 1'b0;
        s_rdata_i = '0;
        scnt      = 0;
        forever begin
            @(negedge clk);
            s_ready_i = 1'b0;
            if (s_valid_o) begin
                scnt++;
                if (slave_lat != 0 && scnt == slave_lat) begin
                    s_ready_i = 1'b1;
                    s_rdata_i = slave_fixed ? slave_rdata : ~s_addr_o;
                end
            end else begin
                scnt = 0;
            end
        end
    end

    // Completion monitor: scoreboard pop, bubble and mux checks.
    initial begin
        logic prev_rdy;
        logic rdy;
        exp_t e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n_i) begin
                prev_rdy = 1'b0;
                continue;
            end
            if (prev_rdy) chk("bubble", {30'd0, gnt_o}, 32'd0);
            if (gnt_o == 2'b01) begin
                chk("mux_c_addr", s_addr_o, core_addr_i);
                chk("mux_c_wstrb", {28'd0, s_wstrb_o}, {28'd0, core_wstrb_i});
            end else if (gnt_o == 2'b10) begin
                chk("mux_d_addr", s_addr_o, dma_addr_i);
                chk("mux_d_wdata", s_wdata_o, dma_wdata_i);
                chk("mux_d_wstrb", {28'd0, s_wstrb_o}, {28'd0, dma_wstrb_i});
            end
            rdy = core_ready_o | dma_ready_o;
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexp_rdy", {30'd0, dma_ready_o, core_ready_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdy_owner", {30'd0, dma_ready_o, core_ready_o},
                        e.mst ? 32'd2 : 32'd1);
                    chk("rdata", e.mst ? dma_rdata_o : core_rdata_o, e.rdata);
                    chk("rdata_other", e.mst ? core_rdata_o : dma_rdata_o, 32'd0);
                    done_cnt++;
                end
            end
            prev_rdy = rdy;
        end
    end

    initial begin
        checks       = 0;
        errors       = 0;
        done_cnt     = 0;
        rst_n_i      = 1'b0;
        core_valid_i = 1'b1;
        core_addr_i  = 32'h0000_1000;
        core_wdata_i = 32'h0;
        core_wstrb_i = 4'h0;
        dma_valid_i  = 1'b1;
        dma_addr_i   = 32'h0000_3000;
        dma_wdata_i  = 32'h0;
        dma_wstrb_i  = 4'h0;
        slave_lat    = 3;
        slave_fixed  = 1'b1;
        slave_rdata  = 32'h1234_5678;

        // Reset with both requests pending, then core-only read.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_svalid", {31'd0, s_valid_o}, 32'd0);
        chk("rst_gnt", {30'd0, gnt_o}, 32'd0);
        chk("rst_crdy", {31'd0, core_ready_o}, 32'd0);
        chk("rst_drdy", {31'd0, dma_ready_o}, 32'd0);
        chk("rst_to", {31'd0, timeout_o}, 32'd0);
        @(negedge clk);
        dma_valid_i = 1'b0;
        rst_n_i     = 1'b1;
        exp_q.push_back({1'b0, 32'h1234_5678});
        @(posedge clk);
        #1;
        chk("lat_t1", {31'd0, s_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_t2", {31'd0, s_valid_o}, 32'd1);
        chk("lat_gnt", {30'd0, gnt_o}, 32'd1);
        wait_done(1, 20);
        core_valid_i = 1'b0;
        chk("to_after_core", {31'd0, timeout_o}, 32'd0);

        // Core wins with DMA waiting, then DMA alone.
        repeat (2) @(posedge clk);
        #1;
        slave_lat    = 2;
        slave_rdata  = 32'hCAFE_0001;
        core_addr_i  = 32'h0000_1100;
        dma_addr_i   = 32'h0000_3100;
        dma_wdata_i  = 32'h0BAD_F00D;
        dma_wstrb_i  = 4'h3;
        core_valid_i = 1'b1;
        dma_valid_i  = 1'b1;
        exp_q.push_back({1'b0, 32'hCAFE_0001});
        exp_q.push_back({1'b1, 32'hCAFE_0001});
        wait_done(2, 20);
        core_valid_i = 1'b0;
        chk("starve_one", {28'd0, dut.starve_q}, 32'd1);
        wait_done(3, 20);
        dma_valid_i = 1'b0;
        chk("starve_clr", {28'd0, dut.starve_q}, 32'd0);

        // Continuous contention: C,C,C,C,D twice.
        repeat (2) @(posedge clk);
        #1;
        slave_lat    = 1;
        slave_fixed  = 1'b0;
        core_addr_i  = 32'h0000_2000;
        dma_addr_i   = 32'h0000_3000;
        dma_wstrb_i  = 4'h0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) exp_q.push_back({1'b0, ~32'h0000_2000});
            exp_q.push_back({1'b1, ~32'h0000_3000});
        end
        core_valid_i = 1'b1;
        dma_valid_i  = 1'b1;
        wait_done(13, 300);
        core_valid_i = 1'b0;
        dma_valid_i  = 1'b0;
        chk("to_after_mix", {31'd0, timeout_o}, 32'd0);

        // Hung DMA write: abort in owner cycle 16.
        repeat (2) @(posedge clk);
        #1;
        slave_lat   = 0;
        dma_addr_i  = 32'h0000_4000;
        dma_wdata_i = 32'h0000_55AA;
        dma_wstrb_i = 4'hF;
        dma_valid_i = 1'b1;
        exp_q.push_back({1'b1, 32'hDEAD_BEEF});
        wait_gnt(2'b10);
        for (int k = 1; k <= 16; k++) begin
            chk("hang_rdy", {31'd0, dma_ready_o}, (k == 16) ? 32'd1 : 32'd0);
            if (k == 16) chk("hang_svalid", {31'd0, s_valid_o}, 32'd0);
            else nclk();
        end
        @(posedge clk);
        #1;
        dma_valid_i = 1'b0;
        chk("hang_to", {31'd0, timeout_o}, 32'd1);
        chk("hang_done", done_cnt, 14);

        // Owner drops valid early: no ready, timeout stays set.
        repeat (2) @(posedge clk);
        #1;
        core_addr_i  = 32'h0000_5000;
        core_valid_i = 1'b1;
        wait_gnt(2'b01);
        @(posedge clk);
        #1;
        core_valid_i = 1'b0;
        nclk();
        chk("drop_rdy", {31'd0, core_ready_o}, 32'd0);
        chk("drop_svalid", {31'd0, s_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("drop_gnt", {30'd0, gnt_o}, 32'd0);
        chk("drop_to", {31'd0, timeout_o}, 32'd1);

        // Async reset in the middle of a core access.
        repeat (2) @(posedge clk);
        #1;
        core_valid_i = 1'b1;
        wait_gnt(2'b01);
        chk("mid_svalid_pre", {31'd0, s_valid_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("mid_svalid", {31'd0, s_valid_o}, 32'd0);
        chk("mid_gnt", {30'd0, gnt_o}, 32'd0);
        chk("mid_to", {31'd0, timeout_o}, 32'd0);
        chk("mid_state", 32'(dut.state_q), 32'd0);
        core_valid_i = 1'b0;
        @(negedge clk);
        rst_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 32'd0);
        chk("final_done", done_cnt, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
